// File: rtl/ikbd_uart_if.sv
// Host-side strobe/data signals plus the two serial pins of the IKBD link.
// The DUT takes the slave view; the IO controller / line side is the master.
interface ikbd_uart_if;
    logic       host_strobe_in;
    logic [7:0] host_data_in;
    logic       tx_out;
    logic       tx_fifo_full;
    logic       rx_in;
    logic       host_data_out_available;
    logic       host_strobe_out;
    logic [7:0] host_data_out;
    logic       rx_overrun;
    logic       rx_frame_error;

    modport master (
        output host_strobe_in, host_data_in, rx_in, host_strobe_out,
        input  tx_out, tx_fifo_full, host_data_out_available, host_data_out,
               rx_overrun, rx_frame_error
    );

    modport slave (
        input  host_strobe_in, host_data_in, rx_in, host_strobe_out,
        output tx_out, tx_fifo_full, host_data_out_available, host_data_out,
               rx_overrun, rx_frame_error
    );
endinterface

// File: rtl/ikbd_uart.sv
// Keyboard end of the IKBD serial link: 8N1 at 16x oversampling, with a byte
// FIFO in each direction towards the IO controller.
module ikbd_uart #(
    parameter int CLK_DIV        = 64,
    parameter int FIFO_ADDR_BITS = 4
) (
    input  logic       clk,
    input  logic       reset,
    ikbd_uart_if.slave bus
);
    localparam int AW = FIFO_ADDR_BITS;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] DIV_ONE  = PW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [PW-1:0] div_cnt;
    logic          tick;

    always_ff @(posedge clk) begin
        if (reset || tick) div_cnt <= '0;
        else               div_cnt <= div_cnt + DIV_ONE;
    end

    assign tick = (div_cnt == DIV_LAST);

    // Strobe synchronizers: _p0 metastable, _p1 synchronized, _p2 previous value
    logic strb_in_p0, strb_in_p1, strb_in_p2;
    logic strb_out_p0, strb_out_p1, strb_out_p2;
    logic push_edge, pop_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            strb_in_p0  <= 1'b0;
            strb_in_p1  <= 1'b0;
            strb_in_p2  <= 1'b0;
            strb_out_p0 <= 1'b0;
            strb_out_p1 <= 1'b0;
            strb_out_p2 <= 1'b0;
        end else begin
            strb_in_p0  <= bus.host_strobe_in;
            strb_in_p1  <= strb_in_p0;
            strb_in_p2  <= strb_in_p1;
            strb_out_p0 <= bus.host_strobe_out;
            strb_out_p1 <= strb_out_p0;
            strb_out_p2 <= strb_out_p1;
        end
    end

    assign push_edge = strb_in_p1 & ~strb_in_p2;
    assign pop_edge  = strb_out_p1 & ~strb_out_p2;

    // TX FIFO; the extra pointer MSB separates full from empty
    logic [7:0]  tx_mem [0:(1<<AW)-1];
    logic [AW:0] tx_wr, tx_rd;
    logic        tx_full, tx_empty, tx_push, tx_pop;

    assign tx_empty = (tx_wr == tx_rd);
    assign tx_full  = (tx_wr[AW-1:0] == tx_rd[AW-1:0]) && (tx_wr[AW] != tx_rd[AW]);
    assign tx_push  = push_edge && !tx_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr <= '0;
            tx_rd <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + PTR_ONE;
            if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr[AW-1:0]] <= bus.host_data_in;
    end

    state_t     tx_state, tx_state_nx;
    logic [3:0] tx_sub;
    logic [2:0] tx_bit;
    logic [7:0] tx_shift;
    logic       tx_sub_end;
    logic       tx_line;

    assign tx_sub_end = tick && (tx_sub == 4'd15);

    always_ff @(posedge clk) begin
        if (reset) tx_state <= S_IDLE;
        else       tx_state <= tx_state_nx;
    end

    always_comb begin
        tx_state_nx = tx_state;
        tx_pop      = 1'b0;
        case (tx_state)
            S_IDLE: begin
                if (tick && !tx_empty) begin
                    tx_pop      = 1'b1;
                    tx_state_nx = S_START;
                end
            end
            S_START: if (tx_sub_end) tx_state_nx = S_DATA;
            S_DATA:  if (tx_sub_end && tx_bit == 3'd7) tx_state_nx = S_STOP;
            S_STOP: begin
                // Chain straight into the next start bit when more bytes wait
                if (tx_sub_end) begin
                    if (!tx_empty) begin
                        tx_pop      = 1'b1;
                        tx_state_nx = S_START;
                    end else begin
                        tx_state_nx = S_IDLE;
                    end
                end
            end
            default: tx_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        tx_line = 1'b1;
        case (tx_state)
            S_START: tx_line = 1'b0;
            S_DATA:  tx_line = tx_shift[0];
            default: tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_sub <= '0;
            tx_bit <= '0;
        end else if (tx_state == S_IDLE || tx_pop) begin
            tx_sub <= '0;
            tx_bit <= '0;
        end else if (tick) begin
            tx_sub <= tx_sub + 4'd1;
            if (tx_sub_end && tx_state == S_DATA) tx_bit <= tx_bit + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_pop)                                 tx_shift <= tx_mem[tx_rd[AW-1:0]];
        else if (tx_sub_end && tx_state == S_DATA)  tx_shift <= {1'b0, tx_shift[7:1]};
    end

    // RX line: _p0/_p1 synchronizer, then a 4-sample majority-free glitch filter
    logic       rx_p0, rx_p1;
    logic [3:0] rx_filt_sh, rx_filt_sh_nx;
    logic       rx_filt;

    assign rx_filt_sh_nx = {rx_filt_sh[2:0], rx_p1};

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_p0      <= 1'b1;
            rx_p1      <= 1'b1;
            rx_filt_sh <= 4'hF;
            rx_filt    <= 1'b1;
        end else begin
            rx_p0 <= bus.rx_in;
            rx_p1 <= rx_p0;
            if (tick) begin
                rx_filt_sh <= rx_filt_sh_nx;
                if (rx_filt_sh_nx == 4'h0)      rx_filt <= 1'b0;
                else if (rx_filt_sh_nx == 4'hF) rx_filt <= 1'b1;
            end
        end
    end

    state_t     rx_state, rx_state_nx;
    logic [3:0] rx_sub;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift;
    logic       rx_sample, rx_wait_high;
    logic       rx_push, rx_pop, rx_ovr_set, rx_ferr_set;
    logic       rx_full, rx_empty;

    assign rx_sample = tick && (rx_sub == 4'd15);

    always_ff @(posedge clk) begin
        if (reset) rx_state <= S_IDLE;
        else       rx_state <= rx_state_nx;
    end

    always_comb begin
        rx_state_nx = rx_state;
        case (rx_state)
            S_IDLE:  if (tick && !rx_filt && !rx_wait_high) rx_state_nx = S_START;
            S_START: if (rx_sample) rx_state_nx = rx_filt ? S_IDLE : S_DATA;
            S_DATA:  if (rx_sample && rx_bit == 3'd7) rx_state_nx = S_STOP;
            S_STOP:  if (rx_sample) rx_state_nx = S_IDLE;
            default: rx_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rx_push     = 1'b0;
        rx_ovr_set  = 1'b0;
        rx_ferr_set = 1'b0;
        if (rx_state == S_STOP && rx_sample) begin
            rx_push     = rx_filt && !rx_full;
            rx_ovr_set  = rx_filt && rx_full;
            rx_ferr_set = !rx_filt;
        end
    end

    // Sub-counter starts at 8 so the first sample lands mid start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sub       <= '0;
            rx_bit       <= '0;
            rx_wait_high <= 1'b0;
        end else begin
            if (rx_state == S_IDLE) begin
                rx_sub <= 4'd8;
                rx_bit <= '0;
            end else if (tick) begin
                rx_sub <= rx_sub + 4'd1;
                if (rx_sample && rx_state == S_DATA) rx_bit <= rx_bit + 3'd1;
            end
            if (rx_ferr_set)  rx_wait_high <= 1'b1;
            else if (rx_filt) rx_wait_high <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_sample && rx_state == S_DATA) rx_shift <= {rx_filt, rx_shift[7:1]};
    end

    logic rx_overrun_q, rx_frame_error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_overrun_q     <= 1'b0;
            rx_frame_error_q <= 1'b0;
        end else begin
            if (rx_ovr_set)  rx_overrun_q     <= 1'b1;
            if (rx_ferr_set) rx_frame_error_q <= 1'b1;
        end
    end

    logic [7:0]  rx_mem [0:(1<<AW)-1];
    logic [AW:0] rx_wr, rx_rd;

    assign rx_empty = (rx_wr == rx_rd);
    assign rx_full  = (rx_wr[AW-1:0] == rx_rd[AW-1:0]) && (rx_wr[AW] != rx_rd[AW]);
    assign rx_pop   = pop_edge && !rx_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr <= '0;
            rx_rd <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + PTR_ONE;
            if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_shift;
    end

    assign bus.tx_out                  = tx_line;
    assign bus.tx_fifo_full            = tx_full;
    assign bus.host_data_out_available = !rx_empty;
    assign bus.host_data_out           = rx_mem[rx_rd[AW-1:0]];
    assign bus.rx_overrun              = rx_overrun_q;
    assign bus.rx_frame_error          = rx_frame_error_q;
endmodule

// File: doc/ikbd_uart.md
Name: ikbd_uart

Overview:
Keyboard-side end of the IKBD serial link. It replaces the shortcut FIFO path with a real 7812.5 bit/s 8N1 serial line to and from a 6850-style ACIA.
- Bytes strobed in by the IO controller are queued and serialized onto tx_out, which drives the ACIA RX pin.
- Frames arriving on rx_in, from the ACIA TX pin, are deserialized and queued for the IO controller.
- Runs in the 8 MHz system clock domain.

Parameters:
CLK_DIV, 64, system clocks per oversample tick (8 MHz/64 = 125 kHz = 16 x 7812.5 bit/s)
FIFO_ADDR_BITS, 4, log2 depth of each FIFO (16 entries)

Ports:
clk  input  1  system clock, 8 MHz; all logic on posedge
reset  input  1  synchronous, active-high reset
host_strobe_in  input  1  IO controller write strobe; asynchronous, rising edge pushes host_data_in
host_data_in  input  8  byte to transmit; stable while host_strobe_in is high
tx_out  output  1  serial data to ACIA RX; idle high
tx_fifo_full  output  1  TX FIFO holds 2^FIFO_ADDR_BITS bytes
rx_in  input  1  serial data from ACIA TX; asynchronous, idle high
host_data_out_available  output  1  RX FIFO not empty
host_strobe_out  input  1  IO controller read strobe; asynchronous, rising edge pops the RX FIFO
host_data_out  output  8  RX FIFO head; valid while host_data_out_available=1
rx_overrun  output  1  sticky: a received byte was dropped because the RX FIFO was full
rx_frame_error  output  1  sticky: a stop bit was sampled low

Behaviour:
Reset (one cycle high, synchronous):
- All FIFO pointers, prescaler, both FSMs and sticky flags cleared.
- tx_out=1, tx_fifo_full=0, host_data_out_available=0, rx_overrun=0, rx_frame_error=0.
- Reset mid-frame: tx_out is 1 on the cycle after reset is sampled; any partial RX frame is discarded.

Prescaler and strobes:
- Free-running counter 0..CLK_DIV-1; tick asserts for one clk when the count equals CLK_DIV-1.
- host_strobe_in and host_strobe_out each pass through a 2-FF synchronizer plus edge detect. One rising edge = one operation, regardless of strobe width.

TX FIFO:
- Push on a detected host_strobe_in edge when not full. When full, the byte is silently dropped and the pointers are unchanged.
- Pointers wrap modulo depth; an extra pointer bit or counter distinguishes full from empty.

TX FSM, states IDLE, START, DATA, STOP; every bit lasts exactly 16 ticks:
- IDLE: tx_out=1. On a tick with FIFO non-empty, pop the head into the shift register and go to START.
- START: tx_out=0 for 16 ticks.
- DATA: 8 bits, LSB first, 16 ticks each.
- STOP: tx_out=1 for 16 ticks. On completion, if the FIFO is non-empty, pop and go directly to START, with no idle gap. Otherwise go to IDLE.
- Frame length = 160 ticks = 10240 clk.
- Latency from the first push into an empty, idle TX FIFO to the tx_out falling edge is at most CLK_DIV+3 clk.

RX:
- rx_in passes a 2-FF synchronizer, then a 4-sample filter shifted on each tick. The filtered level changes only after 4 equal consecutive samples.

RX FSM, states IDLE, START, DATA, STOP:
- IDLE: filtered=0 on a tick moves to START with the sub-counter at 8.
- START: mid-bit (8 ticks later) re-check. If filtered=1, treat as a glitch and return to IDLE. Otherwise go to DATA.
- DATA: sample every 16 ticks, 8 bits LSB first.
- STOP: sample once 16 ticks later.
  - Stop=1: push the byte if the RX FIFO is not full. If full, drop the byte and set rx_overrun.
  - Stop=0: set rx_frame_error, discard the byte, then wait in IDLE until filtered=1 before re-arming.
- Received bytes appear at host_data_out_available within 2 clk of the stop-bit sample.

RX FIFO:
- Pop on a detected host_strobe_out edge when non-empty; a pop while empty is ignored.
- Simultaneous push and pop in the same clk are both performed; occupancy is unchanged.

Test Plan:
1. Reset, then strobe in 0x80 -> tx_out falls within CLK_DIV+3 clk. At 1024-clk intervals: 0 (start), 0,0,0,0,0,0,0,1, 1 (stop); then idle high.
2. Strobe 0x12, 0x34, 0x56 back-to-back -> three contiguous frames spanning 30720 clk, no idle gap; tx_fifo_full never asserted.
3. Strobe 17 bytes with TX busy -> tx_fifo_full=1 after the 16th queued entry; the 17th byte is never transmitted.
4. Drive rx_in with the 8N1 frame 0xA5 at 7812.5 bit/s -> host_data_out_available=1, host_data_out=0xA5. One host_strobe_out pulse -> available=0.
5. Drive rx_in with 0x3C whose stop bit is held low -> rx_frame_error=1, FIFO stays empty. Send 17 valid frames without popping -> rx_overrun=1 and exactly 16 bytes are readable in order.
6. Assert reset mid-TX frame and apply a 2-clk low glitch on rx_in -> tx_out=1 on the next clk; no byte is received and all flags are 0.
